// File: rtl/stat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stat_pkg
//  Description : Shared status codes, status type and fetch-time status
//                classification for the pipelined status tracker.
//  Revision    : 1.0  initial release
// ============================================================================
package stat_pkg;

    typedef logic [2:0] stat_t;

    // BUB marks an empty pipeline slot and never appears on the stat output.
    localparam stat_t STAT_BUB = 3'd0;
    localparam stat_t STAT_AOK = 3'd1;
    localparam stat_t STAT_HLT = 3'd2;
    localparam stat_t STAT_ADR = 3'd3;
    localparam stat_t STAT_INS = 3'd4;

    // An instruction-memory fault dominates an illegal icode, which in turn
    // dominates a halt.
    function automatic stat_t stat_classify(
        input logic [3:0] icode,
        input logic       instr_valid,
        input logic       imem_error
    );
        stat_t st;
        if (imem_error) begin
            st = STAT_ADR;
        end else if (!instr_valid) begin
            st = STAT_INS;
        end else if (icode == 4'h0) begin
            st = STAT_HLT;
        end else begin
            st = STAT_AOK;
        end
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stat_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : stat_stage_reg
//  Description : One pipeline register holding an instruction status and PC,
//                with freeze, bubble and stall control.
//  Revision    : 1.0  initial release
// ============================================================================
module stat_stage_reg
    import stat_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_freeze,
    input  logic            i_bubble,
    input  logic            i_stall,
    input  stat_t           i_d_stat,
    input  logic [PC_W-1:0] i_d_pc,
    output stat_t           o_stat,
    output logic [PC_W-1:0] o_pc
);

    stat_t           r_stat_q;
    stat_t           w_stat_d;
    logic [PC_W-1:0] r_pc_q;
    logic [PC_W-1:0] w_pc_d;

    // Freeze overrides everything; bubble overrides stall; otherwise load.
    always_comb begin
        w_stat_d = r_stat_q;
        w_pc_d   = r_pc_q;
        if (!i_freeze) begin
            if (i_bubble) begin
                w_stat_d = STAT_BUB;
                w_pc_d   = '0;
            end else if (!i_stall) begin
                w_stat_d = i_d_stat;
                w_pc_d   = i_d_pc;
            end
        end
    end

    // Register state; reset empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_q <= STAT_BUB;
            r_pc_q   <= '0;
        end else begin
            r_stat_q <= w_stat_d;
            r_pc_q   <= w_pc_d;
        end
    end

    assign o_stat = r_stat_q;
    assign o_pc   = r_pc_q;

endmodule
`default_nettype wire

// File: rtl/stat_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : stat_pipe
//  Description : Pipelined status tracker. Classifies fetched instructions,
//                carries status/PC down the pipe, merges data-memory faults at
//                M, commits a sticky status at W and runs cycle/retire counts.
//  Revision    : 1.0  initial release
// ============================================================================
module stat_pipe
    import stat_pkg::*;
#(
    parameter int STAGES = 5,   // 3..8, fetch included
    parameter int PC_W   = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        f_icode,
    input  logic              f_instr_valid,
    input  logic              f_imem_error,
    input  logic [PC_W-1:0]   f_pc,
    input  logic [STAGES-2:0] stall,
    input  logic [STAGES-2:0] bubble,
    input  logic              m_dmem_error,
    output logic [2:0]        stat,
    output logic              halted,
    output logic              flush_younger,
    output logic [PC_W-1:0]   exc_pc,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  ret_cnt
);

    localparam int c_NREG  = STAGES - 1;
    localparam int c_M_IDX = STAGES - 3;
    localparam int c_W_IDX = STAGES - 2;

    stat_t           w_f_stat;
    stat_t           w_in_stat  [c_NREG];
    logic [PC_W-1:0] w_in_pc    [c_NREG];
    stat_t           w_reg_stat [c_NREG];
    logic [PC_W-1:0] w_reg_pc   [c_NREG];

    stat_t           r_stat_q;
    stat_t           w_stat_d;
    logic [PC_W-1:0] r_exc_pc_q;
    logic [PC_W-1:0] w_exc_pc_d;
    logic [CNT_W-1:0] r_cyc_cnt_q;
    logic [CNT_W-1:0] w_cyc_cnt_d;
    logic [CNT_W-1:0] r_ret_cnt_q;
    logic [CNT_W-1:0] w_ret_cnt_d;

    logic w_halted;
    logic w_m_fault;
    logic w_w_fault;
    logic w_m_dmem_hit;

    assign w_f_stat = stat_classify(f_icode, f_instr_valid, f_imem_error);

    assign w_halted     = (r_stat_q != STAT_AOK);
    assign w_m_fault    = (w_reg_stat[c_M_IDX] == STAT_HLT) ||
                          (w_reg_stat[c_M_IDX] == STAT_ADR) ||
                          (w_reg_stat[c_M_IDX] == STAT_INS);
    assign w_w_fault    = (w_reg_stat[c_W_IDX] == STAT_HLT) ||
                          (w_reg_stat[c_W_IDX] == STAT_ADR) ||
                          (w_reg_stat[c_W_IDX] == STAT_INS);
    // A data-memory fault only matters for a live, so-far-healthy M slot.
    assign w_m_dmem_hit = m_dmem_error && (w_reg_stat[c_M_IDX] == STAT_AOK);

    // Next-register inputs: fetch feeds D, each register feeds the next, and
    // the M->W hop picks up a data-memory fault as ADR.
    always_comb begin
        w_in_stat[0] = w_f_stat;
        w_in_pc[0]   = f_pc;
        for (int i = 1; i < c_NREG; i++) begin
            w_in_stat[i] = w_reg_stat[i-1];
            w_in_pc[i]   = w_reg_pc[i-1];
        end
        if (w_m_dmem_hit) begin
            w_in_stat[c_W_IDX] = STAT_ADR;
        end
    end

    for (genvar gi = 0; gi < c_NREG; gi++) begin : g_stage
        stat_stage_reg #(
            .PC_W (PC_W)
        ) u_reg (
            .clk      (clk),
            .rst      (rst),
            .i_freeze (w_halted),
            .i_bubble (bubble[gi]),
            .i_stall  (stall[gi]),
            .i_d_stat (w_in_stat[gi]),
            .i_d_pc   (w_in_pc[gi]),
            .o_stat   (w_reg_stat[gi]),
            .o_pc     (w_reg_pc[gi])
        );
    end

    // Commit at W: first fault latches stat/PC (then halted freezes them),
    // healthy instructions retire, and the cycle counter runs until halt.
    always_comb begin
        w_stat_d    = r_stat_q;
        w_exc_pc_d  = r_exc_pc_q;
        w_cyc_cnt_d = r_cyc_cnt_q;
        w_ret_cnt_d = r_ret_cnt_q;
        if (!w_halted) begin
            w_cyc_cnt_d = r_cyc_cnt_q + CNT_W'(1);
            if (w_w_fault) begin
                w_stat_d   = w_reg_stat[c_W_IDX];
                w_exc_pc_d = w_reg_pc[c_W_IDX];
            end else if (w_reg_stat[c_W_IDX] == STAT_AOK) begin
                w_ret_cnt_d = r_ret_cnt_q + CNT_W'(1);
            end
        end
    end

    // Architectural status and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_q    <= STAT_AOK;
            r_exc_pc_q  <= '0;
            r_cyc_cnt_q <= '0;
            r_ret_cnt_q <= '0;
        end else begin
            r_stat_q    <= w_stat_d;
            r_exc_pc_q  <= w_exc_pc_d;
            r_cyc_cnt_q <= w_cyc_cnt_d;
            r_ret_cnt_q <= w_ret_cnt_d;
        end
    end

    assign stat          = r_stat_q;
    assign halted        = w_halted;
    assign flush_younger = w_m_fault || w_w_fault || w_m_dmem_hit;
    assign exc_pc        = r_exc_pc_q;
    assign cyc_cnt       = r_cyc_cnt_q;
    assign ret_cnt       = r_ret_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stat_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stat_pipe
//  Description : Self-checking bench for stat_pipe: directed scenarios plus a
//                randomized run compared against an in-flight queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stat_pipe;

    localparam int STAGES = 5;
    localparam int PC_W   = 64;
    localparam int CNT_W  = 32;
    localparam int NR     = STAGES - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        f_icode;
    logic              f_instr_valid;
    logic              f_imem_error;
    logic [PC_W-1:0]   f_pc;
    logic [NR-1:0]     stall;
    logic [NR-1:0]     bubble;
    logic              m_dmem_error;
    logic [2:0]        stat;
    logic              halted;
    logic              flush_younger;
    logic [PC_W-1:0]   exc_pc;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  ret_cnt;

    stat_pipe #(.STAGES(STAGES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .f_icode       (f_icode),
        .f_instr_valid (f_instr_valid),
        .f_imem_error  (f_imem_error),
        .f_pc          (f_pc),
        .stall         (stall),
        .bubble        (bubble),
        .m_dmem_error  (m_dmem_error),
        .stat          (stat),
        .halted        (halted),
        .flush_younger (flush_younger),
        .exc_pc        (exc_pc),
        .cyc_cnt       (cyc_cnt),
        .ret_cnt       (ret_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of in-flight instructions, index 0 = oldest (W).
    typedef struct packed {
        logic [2:0]      st;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t             mq[$];
    logic [2:0]       m_stat;
    logic [PC_W-1:0]  m_exc;
    logic [CNT_W-1:0] m_cyc;
    logic [CNT_W-1:0] m_ret;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit use_model = 1'b0;
    int hcnt;

    function automatic logic [2:0] ref_class(input logic [3:0] ic, input logic v, input logic ie);
        if (ie)            return 3'd3;
        if (!v)            return 3'd4;
        if (ic == 4'd0)    return 3'd2;
        return 3'd1;
    endfunction

    function automatic bit is_fault(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NR; i++) mq.push_back('0);
        m_stat = 3'd1;
        m_exc  = '0;
        m_cyc  = '0;
        m_ret  = '0;
    endtask

    // One clock edge of the architectural behaviour (D-register bubble only).
    task automatic model_edge();
        ent_t w;
        ent_t m;
        ent_t f;
        if (m_stat != 3'd1) return;
        w = mq[0];
        if (is_fault(w.st)) begin
            m_stat = w.st;
            m_exc  = w.pc;
        end else if (w.st == 3'd1) begin
            m_ret = m_ret + 1;
        end
        m_cyc = m_cyc + 1;
        m = mq[1];
        if (m_dmem_error && m.st == 3'd1) m.st = 3'd3;
        void'(mq.pop_front());
        mq[0] = m;
        f.st = ref_class(f_icode, f_instr_valid, f_imem_error);
        f.pc = f_pc;
        if (bubble[0]) f = '0;
        mq.push_back(f);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_fetch(input logic [3:0] ic, input logic v, input logic ie, input logic [PC_W-1:0] pc);
        f_icode       = ic;
        f_instr_valid = v;
        f_imem_error  = ie;
        f_pc          = pc;
    endtask

    task automatic idle_inputs();
        set_fetch(4'h1, 1'b1, 1'b0, '0);
        stall        = '0;
        bubble       = '0;
        m_dmem_error = 1'b0;
    endtask

    // Called at posedge+1; reset is pulsed between edges.
    task automatic apply_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        if (use_model) begin
            chk("m_stat",   64'(stat),          64'(m_stat));
            chk("m_halted", 64'(halted),        64'(m_stat != 3'd1));
            chk("m_flush",  64'(flush_younger),
                64'(is_fault(mq[0].st) || is_fault(mq[1].st) || (mq[1].st == 3'd1 && m_dmem_error)));
            chk("m_exc_pc", exc_pc,             m_exc);
            chk("m_cyc",    64'(cyc_cnt),       64'(m_cyc));
            chk("m_ret",    64'(ret_cnt),       64'(m_ret));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (use_model) model_edge();
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();
        use_model = 1'b1;

        // Reset state and a six-instruction AOK stream, then empty fetches.
        for (int k = 0; k < 12; k++) begin
            if (k < 6) set_fetch(4'h6, 1'b1, 1'b0, 64'(8 * k));
            bubble[0] = (k >= 6);
            sample();
            if (k == 0) begin
                chk("rst_stat",  64'(stat), 64'd1);
                chk("rst_halt",  64'(halted), 64'd0);
                chk("rst_flush", 64'(flush_younger), 64'd0);
                chk("rst_exc",   exc_pc, 64'd0);
                chk("rst_cyc",   64'(cyc_cnt), 64'd0);
                chk("rst_ret",   64'(ret_cnt), 64'd0);
            end
            chk("aok_cyc", 64'(cyc_cnt), 64'(k));
            if (k == 10) chk("aok_ret6", 64'(ret_cnt), 64'd6);
            tick();
        end

        // Halt fetched in cycle 10 at PC 0x40.
        apply_reset();
        for (int k = 0; k < 19; k++) begin
            if (k == 10) set_fetch(4'h0, 1'b1, 1'b0, 64'h40);
            else         set_fetch(4'h3, 1'b1, 1'b0, 64'h100 + 64'(8 * k));
            sample();
            if (k == 14) chk("hlt_pre", 64'(stat), 64'd1);
            if (k >= 15) begin
                chk("hlt_stat", 64'(stat), 64'd2);
                chk("hlt_halt", 64'(halted), 64'd1);
                chk("hlt_exc",  exc_pc, 64'h40);
                chk("hlt_cyc",  64'(cyc_cnt), 64'd15);
                chk("hlt_ret",  64'(ret_cnt), 64'd10);
            end
            tick();
        end

        // Data-memory fault on the instruction at PC 0x18 while it sits in M.
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            set_fetch(4'h5, 1'b1, 1'b0, 64'(8 * k));
            m_dmem_error = (k == 6);
            sample();
            if (k == 5) chk("dm_flush0", 64'(flush_younger), 64'd0);
            if (k == 6) chk("dm_flush1", 64'(flush_younger), 64'd1);
            if (k == 7) chk("dm_pre",    64'(stat), 64'd1);
            if (k >= 8) begin
                chk("dm_stat", 64'(stat), 64'd3);
                chk("dm_exc",  exc_pc, 64'h18);
                chk("dm_ret",  64'(ret_cnt), 64'd3);
            end
            tick();
        end
        m_dmem_error = 1'b0;

        // Older INS followed by a younger instruction-memory fault.
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      set_fetch(4'h2, 1'b0, 1'b0, 64'h20);
            else if (k == 1) set_fetch(4'h2, 1'b1, 1'b1, 64'h2A);
            else             set_fetch(4'h2, 1'b1, 1'b0, 64'h30 + 64'(k));
            sample();
            if (k < 5) chk("ins_pre", 64'(stat), 64'd1);
            else begin
                chk("ins_stat", 64'(stat), 64'd4);
                chk("ins_exc",  exc_pc, 64'h20);
            end
            tick();
        end

        // D stalled three cycles on a HLT while E is bubbled and stalled.
        use_model = 1'b0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      set_fetch(4'h4, 1'b1, 1'b0, 64'h48);
            else if (k == 1) set_fetch(4'h0, 1'b1, 1'b0, 64'h50);
            else             set_fetch(4'h4, 1'b1, 1'b0, 64'h58 + 64'(k));
            stall[0]  = (k >= 2 && k <= 4);
            stall[1]  = (k >= 2 && k <= 4);
            bubble[1] = (k >= 2 && k <= 4);
            sample();
            if (k == 5) chk("stl_flush0", 64'(flush_younger), 64'd0);
            if (k == 7) chk("stl_flush1", 64'(flush_younger), 64'd1);
            if (k == 8) chk("stl_pre",    64'(stat), 64'd1);
            if (k >= 9) begin
                chk("stl_stat", 64'(stat), 64'd2);
                chk("stl_exc",  exc_pc, 64'h50);
                chk("stl_ret",  64'(ret_cnt), 64'd1);
                chk("stl_cyc",  64'(cyc_cnt), 64'd9);
            end
            tick();
        end
        chk("pre_rst_halt", 64'(halted), 64'd1);

        // Asynchronous reset while halted, observed before any clock edge.
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("arst_stat",  64'(stat), 64'd1);
        chk("arst_halt",  64'(halted), 64'd0);
        chk("arst_flush", 64'(flush_younger), 64'd0);
        chk("arst_exc",   exc_pc, 64'd0);
        chk("arst_cyc",   64'(cyc_cnt), 64'd0);
        chk("arst_ret",   64'(ret_cnt), 64'd0);
        rst = 1'b0;
        model_reset();
        cyc = 0;
        use_model = 1'b1;

        // Fresh AOK stream after the reset.
        for (int k = 0; k < 10; k++) begin
            set_fetch(4'h7, 1'b1, 1'b0, 64'h200 + 64'(8 * k));
            sample();
            tick();
        end
        sample();
        chk("post_rst_ret", 64'(ret_cnt), 64'd6);
        tick();

        // Randomized traffic; reset a few cycles after each halt.
        hcnt = 0;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       set_fetch(4'($urandom), 1'b1, 1'b1, {$urandom, $urandom});
            else if (r < 6)  set_fetch(4'($urandom), 1'b0, 1'b0, {$urandom, $urandom});
            else if (r < 9)  set_fetch(4'h0, 1'b1, 1'b0, {$urandom, $urandom});
            else             set_fetch(4'($urandom_range(1, 15)), 1'b1, 1'b0, {$urandom, $urandom});
            bubble[0]    = ($urandom_range(0, 7) == 0);
            m_dmem_error = ($urandom_range(0, 19) == 0);
            sample();
            tick();
            if (m_stat != 3'd1) hcnt++;
            if (hcnt > 3) begin
                apply_reset();
                hcnt = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stat_pipe.md
# stat_pipe

Parametrised pipelined status tracker for the pipelined Y86-64 core. Classifies each fetched instruction's status (AOK/HLT/ADR/INS), carries it and its PC through STAGES pipeline registers under per-stage stall/bubble control, and merges data-memory errors at the memory stage. At write-back it commits a sticky architectural status, records the faulting PC, and freezes the pipeline. It also drives the younger-instruction suppression signal and the cycle/retire counters.

## Interface
- STAGES, 5, pipeline depth including fetch; legal range 3..8; register index 0 = D … STAGES-2 = W.
- PC_W, 64, PC width.
- CNT_W, 32, counter width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_icode  in  4  fetched icode.
- f_instr_valid  in  1  fetched icode is legal.
- f_imem_error  in  1  instruction-memory fault on fetch.
- f_pc  in  PC_W  fetch PC.
- stall  in  STAGES-1  per-register hold, bit i = register i.
- bubble  in  STAGES-1  per-register bubble insert.
- m_dmem_error  in  1  data-memory fault for the instruction in register STAGES-3 (M).
- stat  out  3  architectural status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- halted  out  1  stat != AOK.
- flush_younger  out  1  M or W holds ADR/INS/HLT; gates memory writes and CC updates.
- exc_pc  out  PC_W  PC of the first non-AOK committed instruction.
- cyc_cnt  out  CNT_W  cycles since reset while not halted.
- ret_cnt  out  CNT_W  AOK instructions committed.

## Operation
- Codes: 0 BUB (bubble, internal only), 1 AOK, 2 HLT, 3 ADR, 4 INS.
- Fetch classification is combinational, with priority f_imem_error→ADR, else !f_instr_valid→INS, else f_icode==0→HLT, else AOK.
- Per register i, on the clock edge with halted=0:
  - bubble[i]: load BUB, PC 0. Bubble wins over stall.
  - else stall[i]: hold.
  - else load from register i-1, or from fetch for i=0.
- M→W merge: if m_dmem_error and M's code is AOK, W loads ADR.
  - m_dmem_error with M code BUB or non-AOK is ignored.
- Commit is evaluated each edge while halted=0.
  - If W code ∈ {HLT, ADR, INS}: stat←W code, exc_pc←W PC. Both are sticky until rst.
  - If W code is AOK: ret_cnt+1.
  - BUB commits nothing.
- halted=1 freezes all stage registers, counters, stat and exc_pc. Inputs are ignored.
- cyc_cnt increments every edge while halted=0 and wraps modulo 2^CNT_W. ret_cnt also wraps.
- flush_younger is combinational: (M code ∈ {2,3,4}) | (W code ∈ {2,3,4}) | (M code==AOK & m_dmem_error).

## Timing
- Reset values: stat=1, halted=0, all registers BUB with PC 0, exc_pc=0, cyc_cnt=0, ret_cnt=0, flush_younger=0.
- Latency: an instruction fetched in cycle t reaches W in cycle t+STAGES-1. Its status is visible on stat/halted in cycle t+STAGES, with no stalls.
- Each cycle of stall on any register in the path adds one cycle.
- A dmem error asserted in cycle c for the M instruction gives stat=ADR in cycle c+2.
- Only the oldest fault commits. Younger faults behind it are frozen and never reach stat.
- rst mid-operation clears everything immediately (asynchronously), including a sticky halt.
- Bubble and stall both asserted on one register: bubble applied.

## Structure
- Shared package stat_pkg holds:
  - localparams STAT_BUB/AOK/HLT/ADR/INS;
  - typedef stat_t (3-bit);
  - function stat_classify(icode, instr_valid, imem_error).
- Sub-module stat_stage_reg, instantiated STAGES-1 times in a generate loop. It holds {stat_t, PC} with stall/bubble/freeze inputs.
- Commit logic, merge and counters live in the top level.

## Test plan
- Reset, then AOK stream of 6 instructions:
  - ret_cnt=6 after the last reaches W;
  - stat=1, cyc_cnt counting each cycle.
- Halt with icode 0 fetched at cycle 10, f_pc=0x40, STAGES=5:
  - stat=2 and halted=1 from cycle 15;
  - exc_pc=0x40; cyc_cnt frozen at 15.
- m_dmem_error with an AOK instruction (PC 0x18) in M at cycle c:
  - flush_younger=1 in cycle c;
  - stat=3 from c+2; exc_pc=0x18.
- Older INS (PC 0x20) followed by an imem error (PC 0x2A): stat=4, exc_pc=0x20, never 3.
- stall[0] held 3 cycles on a HLT in D: stat=2 appears 3 cycles later than the no-stall case. bubble[1] and stall[1] both high: E loads BUB.
- rst pulse while halted=1: all outputs at reset values within the same cycle, and a new AOK stream retires normally.
